// File: rtl/arbitro_ula.sv
// Round-robin arbiter that shares one ALU between two requesters.
// Latches the winner's operands, captures the ALU result a cycle later and pulses done.
module arbitro_ula #(
  parameter int unsigned LARGURA = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [LARGURA-1:0] op0_a,
  input  logic [LARGURA-1:0] op0_b,
  input  logic [2:0]         op0_sel,
  input  logic [LARGURA-1:0] op1_a,
  input  logic [LARGURA-1:0] op1_b,
  input  logic [2:0]         op1_sel,
  output logic [LARGURA-1:0] entrada1,
  output logic [LARGURA-1:0] entrada2,
  output logic [2:0]         sinal_ula,
  input  logic [LARGURA-1:0] saida_ula,
  input  logic               zero,
  output logic [LARGURA-1:0] resultado,
  output logic               zero_out,
  output logic               done0,
  output logic               done1,
  output logic               busy
);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]         state, state_n;
  logic               prio, prio_n;
  logic               dono, dono_n;
  logic               grant;
  logic [LARGURA-1:0] entrada1_n, entrada2_n, resultado_n;
  logic [2:0]         sinal_ula_n;
  logic               zero_out_n;
  logic [1:0]         done_q, done_n;
  logic               busy_n;

  // State and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OCIOSO;
      prio      <= 1'b0;
      dono      <= 1'b0;
      entrada1  <= '0;
      entrada2  <= '0;
      sinal_ula <= 3'b000;
      resultado <= '0;
      zero_out  <= 1'b0;
      done_q    <= 2'b00;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      prio      <= prio_n;
      dono      <= dono_n;
      entrada1  <= entrada1_n;
      entrada2  <= entrada2_n;
      sinal_ula <= sinal_ula_n;
      resultado <= resultado_n;
      zero_out  <= zero_out_n;
      done_q    <= done_n;
      busy      <= busy_n;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    prio_n      = prio;
    dono_n      = dono;
    grant       = 1'b0;
    entrada1_n  = entrada1;
    entrada2_n  = entrada2;
    sinal_ula_n = sinal_ula;
    resultado_n = resultado;
    zero_out_n  = zero_out;
    done_n      = 2'b00;

    case (state)
      OCIOSO: begin
        if (req0 || req1) begin
          // Tie goes to prio; otherwise the lone requester wins
          grant  = (req0 && req1) ? prio : req1;
          dono_n = grant;
          if (grant) begin
            entrada1_n  = op1_a;
            entrada2_n  = op1_b;
            sinal_ula_n = op1_sel;
          end else begin
            entrada1_n  = op0_a;
            entrada2_n  = op0_b;
            sinal_ula_n = op0_sel;
          end
          state_n = EXEC;
        end
      end
      EXEC: begin
        resultado_n = saida_ula;
        zero_out_n  = zero;
        done_n      = dono ? 2'b10 : 2'b01;
        prio_n      = ~dono;
        state_n     = RESP;
      end
      RESP: begin
        state_n = OCIOSO;
      end
      default: begin
        state_n = OCIOSO;
      end
    endcase

    busy_n = (state_n != OCIOSO);
  end

  assign done0 = done_q[0];
  assign done1 = done_q[1];

endmodule

// File: tb/tb_arbitro_ula.sv
// Scoreboard bench for arbitro_ula with a behavioural ALU model on the ALU ports.
module tb_arbitro_ula;

  logic        clock;
  logic        reset;
  logic        req0, req1;
  logic [15:0] op0_a, op0_b, op1_a, op1_b;
  logic [2:0]  op0_sel, op1_sel;
  logic [15:0] entrada1, entrada2;
  logic [2:0]  sinal_ula;
  logic [15:0] saida_ula;
  logic        zero;
  logic [15:0] resultado;
  logic        zero_out;
  logic        done0, done1, busy;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  arbitro_ula #(.LARGURA(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .op0_a(op0_a), .op0_b(op0_b), .op0_sel(op0_sel),
    .op1_a(op1_a), .op1_b(op1_b), .op1_sel(op1_sel),
    .entrada1(entrada1), .entrada2(entrada2), .sinal_ula(sinal_ula),
    .saida_ula(saida_ula), .zero(zero),
    .resultado(resultado), .zero_out(zero_out),
    .done0(done0), .done1(done1), .busy(busy)
  );

  // ALU seen by the arbiter: slt yields all ones when true, unused codes give 0
  always_comb begin
    case (sinal_ula)
      3'b000:  saida_ula = entrada1 & entrada2;
      3'b001:  saida_ula = entrada1 | entrada2;
      3'b010:  saida_ula = entrada1 + entrada2;
      3'b011:  saida_ula = entrada1 - entrada2;
      3'b100:  saida_ula = ($signed(entrada1) < $signed(entrada2)) ? 16'hFFFF : 16'h0000;
      default: saida_ula = 16'h0000;
    endcase
    zero = (saida_ula == 16'h0000);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  task automatic push_exp(input logic id, input logic [15:0] res, input logic z);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.z   = z;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset) begin
      if (done0 && done1) begin
        fail_now("both_done");
      end else if (done0 || done1) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("done_id", 32'(done1), 32'(e.id));
          chk("resultado", 32'(resultado), 32'(e.res));
          chk("zero_out", 32'(zero_out), 32'(e.z));
        end
      end
    end
  end

  // One request from an idle arbiter; optional hold of req through RESP
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] sel, input logic [15:0] er, input logic ez,
                        input logic hold);
    logic got;
    got = 1'b0;
    @(negedge clock);
    push_exp(id, er, ez);
    if (id) begin
      op1_a = a; op1_b = b; op1_sel = sel; req1 = 1'b1;
    end else begin
      op0_a = a; op0_b = b; op0_sel = sel; req0 = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if ((!id && done0) || (id && done1)) begin
        got = 1'b1;
        chk("op_latency", 32'(k), 32'd2);
        break;
      end
    end
    if (!got) fail_now("op_timeout");
    if (hold) begin
      @(negedge clock);
      chk("no_regrant_busy", 32'(busy), 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Both requesters held high for two operations each
  task automatic run_tie(input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] s0,
                         input logic [15:0] er0, input logic ez0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] s1,
                         input logic [15:0] er1, input logic ez1);
    int d0, d1, first0, first1;
    d0 = 0; d1 = 0; first0 = -1; first1 = -1;
    @(negedge clock);
    push_exp(1'b0, er0, ez0);
    push_exp(1'b1, er1, ez1);
    push_exp(1'b0, er0, ez0);
    push_exp(1'b1, er1, ez1);
    op0_a = a0; op0_b = b0; op0_sel = s0;
    op1_a = a1; op1_b = b1; op1_sel = s1;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done0) begin
        if (d0 == 0) first0 = k;
        d0++;
        if (d0 == 2) req0 = 1'b0;
      end
      if (done1) begin
        if (d1 == 0) first1 = k;
        d1++;
        if (d1 == 2) req1 = 1'b0;
      end
      if (d0 == 2 && d1 == 2) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("tie_done0_cycle", 32'(first0), 32'd2);
    chk("tie_done1_cycle", 32'(first1), 32'd5);
    chk("tie_done0_count", 32'(d0), 32'd2);
    chk("tie_done1_count", 32'(d1), 32'd2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    op0_a = '0; op0_b = '0; op0_sel = '0;
    op1_a = '0; op1_b = '0; op1_sel = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_entrada1", 32'(entrada1), 32'd0);
    chk("rst_sinal_ula", 32'(sinal_ula), 32'd0);
    chk("rst_resultado", 32'(resultado), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Test 1: and of disjoint masks, with cycle-by-cycle checks
    @(negedge clock);
    push_exp(1'b0, 16'h0000, 1'b1);
    op0_a = 16'h00F0; op0_b = 16'h0F0F; op0_sel = 3'b000; req0 = 1'b1;
    @(negedge clock);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_entrada1", 32'(entrada1), 32'h00F0);
    chk("t1_entrada2", 32'(entrada2), 32'h0F0F);
    chk("t1_sinal", 32'(sinal_ula), 32'd0);
    chk("t1_done0_c1", 32'(done0), 32'd0);
    @(negedge clock);
    chk("t1_busy_c2", 32'(busy), 32'd1);
    chk("t1_done0_c2", 32'(done0), 32'd1);
    req0 = 1'b0;
    @(negedge clock);
    chk("t1_busy_c3", 32'(busy), 32'd0);
    chk("t1_done0_c3", 32'(done0), 32'd0);

    // Test 2: sub from requester 1
    run_op(1'b1, 16'd5, 16'd9, 3'b011, 16'hFFFC, 1'b0, 1'b0);

    // Test 3: both held, alternating grants
    run_tie(16'd1, 16'd1, 3'b010, 16'h0002, 1'b0,
            16'd3, 16'd4, 3'b001, 16'h0007, 1'b0);

    // Test 4: slt true then false; first request held through RESP
    run_op(1'b1, 16'd3, 16'd7, 3'b100, 16'hFFFF, 1'b0, 1'b1);
    run_op(1'b1, 16'd7, 16'd3, 3'b100, 16'h0000, 1'b1, 1'b0);

    // Test 6: unused op code
    run_op(1'b0, 16'h1234, 16'h5678, 3'b111, 16'h0000, 1'b1, 1'b0);

    // Test 5: leave prio at 1, then abort an operation in EXEC
    run_op(1'b0, 16'd2, 16'd3, 3'b010, 16'h0005, 1'b0, 1'b0);
    @(negedge clock);
    op0_a = 16'hAAAA; op0_b = 16'h5555; op0_sel = 3'b001; req0 = 1'b1;
    @(negedge clock);
    chk("abort_busy_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_entrada1", 32'(entrada1), 32'd0);
    chk("abort_entrada2", 32'(entrada2), 32'd0);
    chk("abort_sinal", 32'(sinal_ula), 32'd0);
    chk("abort_resultado", 32'(resultado), 32'd0);
    chk("abort_zero_out", 32'(zero_out), 32'd0);
    chk("abort_done", 32'({done1, done0}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    req0 = 1'b0;
    @(negedge clock);
    chk("abort_no_done", 32'({done1, done0}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_idle_done", 32'({done1, done0}), 32'd0);

    // Requester 0 must win the first tie after reset
    run_tie(16'h00F0, 16'h000F, 3'b001, 16'h00FF, 1'b0,
            16'd4, 16'd4, 3'b011, 16'h0000, 1'b1);

    repeat (4) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
